// File: rtl/vxe_axi4_pkg.sv
// Shared AXI4 constants for the BIU masters.
// Holds the fixed burst/cache/prot attributes, the response codes and a helper
// that turns a data-bus width into the AxSIZE encoding.
package vxe_axi4_pkg;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [3:0] AXI_CACHE   = 4'b0011;  // bufferable + modifiable
    localparam logic [2:0] AXI_PROT    = 3'b000;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // AxSIZE for a single full-width beat
    function automatic logic [2:0] axi_size(input int unsigned data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/vxe_axi4_skid.sv
// One-entry response skid register.
// Captures an AXI response beat and pushes it into a downstream FIFO. A capture
// and a drain in the same cycle replace the entry, so one beat per cycle flows.
// Ports:
//   clk_i, rst_i       clock, asynchronous active-high reset
//   in_valid_i/_data_i AXI side beat (xVALID and payload)
//   in_ready_o         AXI side xREADY
//   out_ready_i        downstream FIFO not full
//   out_push_o         downstream push strobe
//   out_data_o         entry presented to the downstream FIFO
module vxe_axi4_skid #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             in_ready_o,
    input  logic             out_ready_i,
    output logic             out_push_o,
    output logic [WIDTH-1:0] out_data_o
);

    logic             full_q, full_d;
    logic [WIDTH-1:0] data_q;
    logic             capture;

    assign in_ready_o = !full_q || out_ready_i;
    assign out_push_o = full_q && out_ready_i;
    assign out_data_o = data_q;
    assign capture    = in_valid_i && in_ready_o;

    always_comb begin
        full_d = full_q;
        if (capture) begin
            full_d = 1'b1;
        end else if (out_push_o) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
        end else begin
            full_q <= full_d;
        end
    end

    // Payload carries no reset; full_q qualifies it.
    always_ff @(posedge clk_i) begin
        if (capture) begin
            data_q <= in_data_i;
        end
    end

endmodule

// File: rtl/vxe_axi4mas_biu_mo.sv
// AXI4 master bus interface unit with multiple outstanding transactions.
// Pops single-beat write/read requests from BIU request FIFOs, issues them on
// AXI4 (AW+W, AR) and pushes B/R responses into BIU response FIFOs. The client
// ID travels as the AXI ID so responses can return out of order.
// Ports:
//   M_AXI4_ACLK/ARESET   clock, asynchronous active-high reset
//   M_AXI4_AW*/W*/B*     write address, data and response channels
//   M_AXI4_AR*/R*        read address and data channels
//   biu_aw*/biu_awpop    write request FIFO head and pop
//   biu_b*/biu_bpush     write response FIFO push
//   biu_ar*/biu_arpop    read request FIFO head and pop
//   biu_r*/biu_rpush     read response FIFO push
module vxe_axi4mas_biu_mo
    import vxe_axi4_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned CID_WIDTH  = 8,
    parameter int unsigned MAX_OUTST  = 4
) (
    input  logic                    M_AXI4_ACLK,
    input  logic                    M_AXI4_ARESET,
    output logic [ID_WIDTH-1:0]     M_AXI4_AWID,
    output logic [ADDR_WIDTH-1:0]   M_AXI4_AWADDR,
    output logic [7:0]              M_AXI4_AWLEN,
    output logic [2:0]              M_AXI4_AWSIZE,
    output logic [1:0]              M_AXI4_AWBURST,
    output logic                    M_AXI4_AWLOCK,
    output logic [3:0]              M_AXI4_AWCACHE,
    output logic [2:0]              M_AXI4_AWPROT,
    output logic                    M_AXI4_AWVALID,
    input  logic                    M_AXI4_AWREADY,
    output logic [DATA_WIDTH-1:0]   M_AXI4_WDATA,
    output logic [DATA_WIDTH/8-1:0] M_AXI4_WSTRB,
    output logic                    M_AXI4_WLAST,
    output logic                    M_AXI4_WVALID,
    input  logic                    M_AXI4_WREADY,
    input  logic [ID_WIDTH-1:0]     M_AXI4_BID,
    input  logic [1:0]              M_AXI4_BRESP,
    input  logic                    M_AXI4_BVALID,
    output logic                    M_AXI4_BREADY,
    output logic [ID_WIDTH-1:0]     M_AXI4_ARID,
    output logic [ADDR_WIDTH-1:0]   M_AXI4_ARADDR,
    output logic [7:0]              M_AXI4_ARLEN,
    output logic [2:0]              M_AXI4_ARSIZE,
    output logic [1:0]              M_AXI4_ARBURST,
    output logic                    M_AXI4_ARLOCK,
    output logic [3:0]              M_AXI4_ARCACHE,
    output logic [2:0]              M_AXI4_ARPROT,
    output logic                    M_AXI4_ARVALID,
    input  logic                    M_AXI4_ARREADY,
    input  logic [ID_WIDTH-1:0]     M_AXI4_RID,
    input  logic [DATA_WIDTH-1:0]   M_AXI4_RDATA,
    input  logic [1:0]              M_AXI4_RRESP,
    input  logic                    M_AXI4_RLAST,
    input  logic                    M_AXI4_RVALID,
    output logic                    M_AXI4_RREADY,
    input  logic [CID_WIDTH-1:0]    biu_awcid,
    input  logic [ADDR_WIDTH-1:0]   biu_awaddr,
    input  logic [DATA_WIDTH-1:0]   biu_awdata,
    input  logic [DATA_WIDTH/8-1:0] biu_awstrb,
    input  logic                    biu_awvalid,
    output logic                    biu_awpop,
    output logic [CID_WIDTH-1:0]    biu_bcid,
    output logic [1:0]              biu_bresp,
    input  logic                    biu_bready,
    output logic                    biu_bpush,
    input  logic [CID_WIDTH-1:0]    biu_arcid,
    input  logic [ADDR_WIDTH-1:0]   biu_araddr,
    input  logic                    biu_arvalid,
    output logic                    biu_arpop,
    output logic [CID_WIDTH-1:0]    biu_rcid,
    output logic [DATA_WIDTH-1:0]   biu_rdata,
    output logic [1:0]              biu_rresp,
    input  logic                    biu_rready,
    output logic                    biu_rpush
);

    localparam int unsigned   CntW   = $clog2(MAX_OUTST + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MAX_OUTST);
    localparam int unsigned   BW     = CID_WIDTH + 2;
    localparam int unsigned   RW     = CID_WIDTH + DATA_WIDTH + 2;

    logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
    logic [CntW-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic [ID_WIDTH-1:0]     awid_q, arid_q;
    logic [ADDR_WIDTH-1:0]   awaddr_q, araddr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] wstrb_q;
    logic aw_free, w_free, ar_free, aw_pop, ar_pop;
    logic [BW-1:0] b_out;
    logic [RW-1:0] r_out;
    logic unused_in;

    // RLAST is ignored; upper ID bits beyond the client ID carry nothing.
    assign unused_in = ^{M_AXI4_RLAST, M_AXI4_BID, M_AXI4_RID};

    // A register is free when empty or being handshaked this cycle.
    assign aw_free = !awvalid_q || M_AXI4_AWREADY;
    assign w_free  = !wvalid_q || M_AXI4_WREADY;
    assign ar_free = !arvalid_q || M_AXI4_ARREADY;

    // Pops are gated by reset so nothing leaves the request FIFOs while in reset.
    assign aw_pop = !M_AXI4_ARESET && biu_awvalid && (wr_cnt_q < CntMax) && aw_free && w_free;
    assign ar_pop = !M_AXI4_ARESET && biu_arvalid && (rd_cnt_q < CntMax) && ar_free;
    assign biu_awpop = aw_pop;
    assign biu_arpop = ar_pop;

    always_comb begin
        awvalid_d = aw_pop || (awvalid_q && !M_AXI4_AWREADY);
        wvalid_d  = aw_pop || (wvalid_q && !M_AXI4_WREADY);
        arvalid_d = ar_pop || (arvalid_q && !M_AXI4_ARREADY);

        wr_cnt_d = wr_cnt_q;
        if (aw_pop && !biu_bpush) begin
            wr_cnt_d = wr_cnt_q + CntW'(1);
        end else if (!aw_pop && biu_bpush && (wr_cnt_q != '0)) begin
            wr_cnt_d = wr_cnt_q - CntW'(1);
        end

        rd_cnt_d = rd_cnt_q;
        if (ar_pop && !biu_rpush) begin
            rd_cnt_d = rd_cnt_q + CntW'(1);
        end else if (!ar_pop && biu_rpush && (rd_cnt_q != '0)) begin
            rd_cnt_d = rd_cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge M_AXI4_ACLK or posedge M_AXI4_ARESET) begin
        if (M_AXI4_ARESET) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
        end else begin
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
        end
    end

    // Payload only loads on pop, which can only happen when the register is free,
    // so it stays stable while VALID is waiting for READY.
    always_ff @(posedge M_AXI4_ACLK) begin
        if (aw_pop) begin
            awid_q   <= ID_WIDTH'(biu_awcid);
            awaddr_q <= biu_awaddr;
            wdata_q  <= biu_awdata;
            wstrb_q  <= biu_awstrb;
        end
        if (ar_pop) begin
            arid_q   <= ID_WIDTH'(biu_arcid);
            araddr_q <= biu_araddr;
        end
    end

    assign M_AXI4_AWID    = awid_q;
    assign M_AXI4_AWADDR  = awaddr_q;
    assign M_AXI4_AWVALID = awvalid_q;
    assign M_AXI4_WDATA   = wdata_q;
    assign M_AXI4_WSTRB   = wstrb_q;
    assign M_AXI4_WVALID  = wvalid_q;
    assign M_AXI4_WLAST   = wvalid_q;
    assign M_AXI4_ARID    = arid_q;
    assign M_AXI4_ARADDR  = araddr_q;
    assign M_AXI4_ARVALID = arvalid_q;

    assign M_AXI4_AWLEN   = 8'd0;
    assign M_AXI4_AWSIZE  = axi_size(DATA_WIDTH);
    assign M_AXI4_AWBURST = BURST_INCR;
    assign M_AXI4_AWLOCK  = 1'b0;
    assign M_AXI4_AWCACHE = AXI_CACHE;
    assign M_AXI4_AWPROT  = AXI_PROT;
    assign M_AXI4_ARLEN   = 8'd0;
    assign M_AXI4_ARSIZE  = axi_size(DATA_WIDTH);
    assign M_AXI4_ARBURST = BURST_INCR;
    assign M_AXI4_ARLOCK  = 1'b0;
    assign M_AXI4_ARCACHE = AXI_CACHE;
    assign M_AXI4_ARPROT  = AXI_PROT;

    vxe_axi4_skid #(
        .WIDTH (BW)
    ) u_b_skid (
        .clk_i       (M_AXI4_ACLK),
        .rst_i       (M_AXI4_ARESET),
        .in_valid_i  (M_AXI4_BVALID),
        .in_data_i   ({M_AXI4_BID[CID_WIDTH-1:0], M_AXI4_BRESP}),
        .in_ready_o  (M_AXI4_BREADY),
        .out_ready_i (biu_bready),
        .out_push_o  (biu_bpush),
        .out_data_o  (b_out)
    );

    vxe_axi4_skid #(
        .WIDTH (RW)
    ) u_r_skid (
        .clk_i       (M_AXI4_ACLK),
        .rst_i       (M_AXI4_ARESET),
        .in_valid_i  (M_AXI4_RVALID),
        .in_data_i   ({M_AXI4_RID[CID_WIDTH-1:0], M_AXI4_RDATA, M_AXI4_RRESP}),
        .in_ready_o  (M_AXI4_RREADY),
        .out_ready_i (biu_rready),
        .out_push_o  (biu_rpush),
        .out_data_o  (r_out)
    );

    assign {biu_bcid, biu_bresp}            = b_out;
    assign {biu_rcid, biu_rdata, biu_rresp} = r_out;

endmodule

// File: tb/tb_vxe_axi4mas_biu_mo.sv
module tb_vxe_axi4mas_biu_mo;

    localparam int MO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  awid, arid, awlen, arlen, bid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [2:0]  awsize, arsize, awprot, arprot;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [3:0]  awcache, arcache, wstrb;
    logic        awlock, arlock, awvalid, awready, wlast, wvalid, wready;
    logic        bvalid, bready, arvalid, arready, rlast, rvalid, rready;
    logic [7:0]  biu_awcid, biu_bcid, biu_arcid, biu_rcid;
    logic [31:0] biu_awaddr, biu_awdata, biu_araddr, biu_rdata;
    logic [3:0]  biu_awstrb;
    logic [1:0]  biu_bresp, biu_rresp;
    logic        biu_awvalid, biu_awpop, biu_bready, biu_bpush;
    logic        biu_arvalid, biu_arpop, biu_rready, biu_rpush;

    always #5 clk = ~clk;

    vxe_axi4mas_biu_mo dut (
        .M_AXI4_ACLK(clk), .M_AXI4_ARESET(rst),
        .M_AXI4_AWID(awid), .M_AXI4_AWADDR(awaddr), .M_AXI4_AWLEN(awlen),
        .M_AXI4_AWSIZE(awsize), .M_AXI4_AWBURST(awburst), .M_AXI4_AWLOCK(awlock),
        .M_AXI4_AWCACHE(awcache), .M_AXI4_AWPROT(awprot), .M_AXI4_AWVALID(awvalid),
        .M_AXI4_AWREADY(awready),
        .M_AXI4_WDATA(wdata), .M_AXI4_WSTRB(wstrb), .M_AXI4_WLAST(wlast),
        .M_AXI4_WVALID(wvalid), .M_AXI4_WREADY(wready),
        .M_AXI4_BID(bid), .M_AXI4_BRESP(bresp), .M_AXI4_BVALID(bvalid), .M_AXI4_BREADY(bready),
        .M_AXI4_ARID(arid), .M_AXI4_ARADDR(araddr), .M_AXI4_ARLEN(arlen),
        .M_AXI4_ARSIZE(arsize), .M_AXI4_ARBURST(arburst), .M_AXI4_ARLOCK(arlock),
        .M_AXI4_ARCACHE(arcache), .M_AXI4_ARPROT(arprot), .M_AXI4_ARVALID(arvalid),
        .M_AXI4_ARREADY(arready),
        .M_AXI4_RID(rid), .M_AXI4_RDATA(rdata), .M_AXI4_RRESP(rresp), .M_AXI4_RLAST(rlast),
        .M_AXI4_RVALID(rvalid), .M_AXI4_RREADY(rready),
        .biu_awcid(biu_awcid), .biu_awaddr(biu_awaddr), .biu_awdata(biu_awdata),
        .biu_awstrb(biu_awstrb), .biu_awvalid(biu_awvalid), .biu_awpop(biu_awpop),
        .biu_bcid(biu_bcid), .biu_bresp(biu_bresp), .biu_bready(biu_bready),
        .biu_bpush(biu_bpush),
        .biu_arcid(biu_arcid), .biu_araddr(biu_araddr), .biu_arvalid(biu_arvalid),
        .biu_arpop(biu_arpop),
        .biu_rcid(biu_rcid), .biu_rdata(biu_rdata), .biu_rresp(biu_rresp),
        .biu_rready(biu_rready), .biu_rpush(biu_rpush)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: queues of requests waiting on each AXI channel and of
    // responses waiting to be pushed, plus outstanding counts per direction.
    typedef struct packed {logic [7:0] cid; logic [31:0] addr; logic [31:0] data; logic [3:0] strb;} wreq_t;
    typedef struct packed {logic [7:0] cid; logic [31:0] addr;} rreq_t;
    typedef struct packed {logic [7:0] cid; logic [31:0] data; logic [1:0] resp;} rsp_t;

    wreq_t aw_q[$];
    wreq_t w_q[$];
    rreq_t ar_q[$];
    rsp_t  b_q[$];
    rsp_t  r_q[$];
    int    wr_out = 0, rd_out = 0;
    int    awpop_cnt = 0, arpop_cnt = 0;
    bit    aw_busy, w_busy, ar_busy, b_full, r_full, exp_awpop, exp_arpop, b_take, r_take;

    always @(negedge clk) begin
        if (biu_awpop) awpop_cnt++;
        if (biu_arpop) arpop_cnt++;
        if (rst) begin
            check("reset_quiet", {awvalid, wvalid, arvalid, biu_awpop, biu_arpop, biu_bpush,
                                  biu_rpush}, '0);
            aw_q.delete(); w_q.delete(); ar_q.delete(); b_q.delete(); r_q.delete();
            wr_out = 0;
            rd_out = 0;
        end else begin
            aw_busy   = aw_q.size() != 0;
            w_busy    = w_q.size() != 0;
            ar_busy   = ar_q.size() != 0;
            b_full    = b_q.size() != 0;
            r_full    = r_q.size() != 0;
            exp_awpop = biu_awvalid && wr_out < MO && (!aw_busy || awready) && (!w_busy || wready);
            exp_arpop = biu_arvalid && rd_out < MO && (!ar_busy || arready);
            b_take    = b_full && biu_bready;
            r_take    = r_full && biu_rready;

            check("valids", {awvalid, wvalid, wlast, arvalid}, {aw_busy, w_busy, w_busy, ar_busy});
            check("readies", {bready, rready}, {!b_full || biu_bready, !r_full || biu_rready});
            check("pops", {biu_awpop, biu_arpop}, {exp_awpop, exp_arpop});
            check("pushes", {biu_bpush, biu_rpush}, {b_take, r_take});
            check("consts", {awlen, awsize, awburst, awlock, awcache, awprot,
                             arlen, arsize, arburst, arlock, arcache, arprot},
                  {8'd0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000, 8'd0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000});
            if (aw_busy) check("aw_payload", {awid, awaddr}, {aw_q[0].cid, aw_q[0].addr});
            if (w_busy)  check("w_payload", {wdata, wstrb}, {w_q[0].data, w_q[0].strb});
            if (ar_busy) check("ar_payload", {arid, araddr}, {ar_q[0].cid, ar_q[0].addr});
            if (b_take)  check("b_payload", {biu_bcid, biu_bresp}, {b_q[0].cid, b_q[0].resp});
            if (r_take)  check("r_payload", {biu_rcid, biu_rdata, biu_rresp},
                               {r_q[0].cid, r_q[0].data, r_q[0].resp});

            // advance the model to the state after the coming edge
            if (aw_busy && awready) void'(aw_q.pop_front());
            if (w_busy && wready)   void'(w_q.pop_front());
            if (ar_busy && arready) void'(ar_q.pop_front());
            if (b_take) begin void'(b_q.pop_front()); if (wr_out > 0) wr_out--; end
            if (r_take) begin void'(r_q.pop_front()); if (rd_out > 0) rd_out--; end
            if (bvalid && (!b_full || biu_bready)) b_q.push_back('{bid, 32'h0, bresp});
            if (rvalid && (!r_full || biu_rready)) r_q.push_back('{rid, rdata, rresp});
            if (exp_awpop) begin
                aw_q.push_back('{biu_awcid, biu_awaddr, biu_awdata, biu_awstrb});
                w_q.push_back('{biu_awcid, biu_awaddr, biu_awdata, biu_awstrb});
                wr_out++;
            end
            if (exp_arpop) begin
                ar_q.push_back('{biu_arcid, biu_araddr});
                rd_out++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int base;

    initial begin
        rst = 1'b1;
        awready = 1'b1; wready = 1'b1; arready = 1'b1;
        bvalid = 1'b0; bid = '0; bresp = '0;
        rvalid = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0;
        biu_awcid = '0; biu_awaddr = '0; biu_awdata = '0; biu_awstrb = '0; biu_awvalid = 1'b0;
        biu_arcid = '0; biu_araddr = '0; biu_arvalid = 1'b0;
        biu_bready = 1'b1; biu_rready = 1'b1;
        step(); step();
        rst = 1'b0;
        step();
        check("after_reset", {awvalid, wvalid, arvalid, biu_bpush, biu_rpush}, '0);

        // single write, everything ready
        base = awpop_cnt;
        biu_awcid = 8'hfe; biu_awaddr = 32'h0000_000c; biu_awdata = 32'hfefe_fafa;
        biu_awstrb = 4'hf; biu_awvalid = 1'b1;
        #1 check("t1_awpop", biu_awpop, 1'b1);
        step();
        biu_awvalid = 1'b0;
        check("t1_aw", {awvalid, awid, awaddr}, {1'b1, 8'hfe, 32'h0000_000c});
        check("t1_w", {wvalid, wlast, wdata}, {1'b1, 1'b1, 32'hfefe_fafa});
        step();
        check("t1_idle", {awvalid, wvalid}, 2'b00);
        bvalid = 1'b1; bid = 8'hfe; bresp = 2'b00;
        step();
        bvalid = 1'b0;
        check("t1_bpush", {biu_bpush, biu_bcid, biu_bresp}, {1'b1, 8'hfe, 2'b00});
        step();
        check("t1_pops", awpop_cnt - base, 1);

        // AWREADY stalled while W goes through
        base = awpop_cnt;
        awready = 1'b0;
        biu_awcid = 8'h01; biu_awaddr = 32'h100; biu_awdata = 32'h1111_1111; biu_awvalid = 1'b1;
        step();
        biu_awcid = 8'h02; biu_awaddr = 32'h200; biu_awdata = 32'h2222_2222;
        check("t2_both", {awvalid, wvalid, biu_awpop}, 3'b110);
        step();
        check("t2_wdrop", {awvalid, wvalid, biu_awpop}, 3'b100);
        step(); step();
        check("t2_awhold", {awvalid, awaddr}, {1'b1, 32'h100});
        check("t2_onepop", awpop_cnt - base, 1);
        awready = 1'b1;
        #1 check("t2_popnow", biu_awpop, 1'b1);
        step();
        biu_awvalid = 1'b0;
        check("t2_second", {awvalid, awid, awaddr}, {1'b1, 8'h02, 32'h200});
        step();
        check("t2_pops", awpop_cnt - base, 2);
        bvalid = 1'b1; bid = 8'h01; bresp = 2'b10;
        step();
        bid = 8'h02; bresp = 2'b00;
        check("t2_b1", {biu_bpush, biu_bcid, biu_bresp}, {1'b1, 8'h01, 2'b10});
        step();
        bvalid = 1'b0;
        check("t2_b2", {biu_bpush, biu_bcid}, {1'b1, 8'h02});
        step(); step();

        // read outstanding limit
        base = arpop_cnt;
        biu_arcid = 8'h33; biu_araddr = 32'h40; biu_arvalid = 1'b1;
        repeat (10) step();
        check("t3_four", arpop_cnt - base, 4);
        check("t3_idle", {arvalid, biu_arpop}, 2'b00);
        rvalid = 1'b1; rid = 8'h33; rdata = 32'h1234_5678; rresp = 2'b00; rlast = 1'b1;
        step();
        rvalid = 1'b0;
        check("t3_rpush", {biu_rpush, biu_arpop, biu_rdata}, {1'b1, 1'b0, 32'h1234_5678});
        step();
        check("t3_fifth", biu_arpop, 1'b1);
        step();
        biu_arvalid = 1'b0;
        check("t3_five", arpop_cnt - base, 5);
        for (int i = 0; i < 4; i++) begin
            rvalid = 1'b1; rdata = 32'ha000_0000 + 32'(i); rlast = 1'b0;
            step();
        end
        rvalid = 1'b0;
        step(); step();

        // response sink not ready
        biu_rready = 1'b0;
        biu_arcid = 8'h44; biu_araddr = 32'h80; biu_arvalid = 1'b1;
        step();
        biu_arvalid = 1'b0;
        step();
        rvalid = 1'b1; rid = 8'h44; rdata = 32'hdede_dada; rresp = 2'b00;
        step();
        rvalid = 1'b0;
        check("t4_hold", {rready, biu_rpush}, 2'b00);
        step();
        check("t4_still", {rready, biu_rpush}, 2'b00);
        biu_rready = 1'b1;
        #1 check("t4_push", {biu_rpush, biu_rcid, biu_rdata}, {1'b1, 8'h44, 32'hdede_dada});
        step();
        check("t4_empty", {biu_rpush, rready}, 2'b01);

        // pop and bpush together near the write limit
        base = awpop_cnt;
        biu_awcid = 8'h55; biu_awaddr = 32'h500; biu_awdata = 32'h5555_5555; biu_awvalid = 1'b1;
        repeat (8) step();
        check("t5_full", {32'(awpop_cnt - base), biu_awpop}, {32'd4, 1'b0});
        bvalid = 1'b1; bid = 8'h55; bresp = 2'b00;
        step();
        check("t5_b1", {biu_bpush, biu_awpop}, 2'b10);
        step();
        bvalid = 1'b0;
        check("t5_both", {biu_bpush, biu_awpop}, 2'b11);
        step();
        check("t5_again", {biu_bpush, biu_awpop}, 2'b01);
        step();
        check("t5_cap", biu_awpop, 1'b0);
        biu_awvalid = 1'b0;
        check("t5_pops", awpop_cnt - base, 6);
        bvalid = 1'b1;
        step(); step();
        bvalid = 1'b0;
        step(); step();

        // reset with writes outstanding and a response parked in the skid
        awready = 1'b0; biu_bready = 1'b0;
        biu_awcid = 8'h66; biu_awaddr = 32'h600; biu_awvalid = 1'b1;
        step();
        bvalid = 1'b1; bid = 8'h66;
        step();
        bvalid = 1'b0;
        check("t6_pre", {awvalid, bready}, 2'b10);
        rst = 1'b1;
        #1 check("t6_rst", {awvalid, wvalid, arvalid, biu_awpop, biu_arpop, biu_bpush,
                            biu_rpush}, '0);
        biu_bready = 1'b1;
        step(); step();
        rst = 1'b0;
        awready = 1'b1;
        base = awpop_cnt;
        check("t6_nobpush", biu_bpush, 1'b0);
        repeat (8) step();
        check("t6_cnt0", awpop_cnt - base, 4);
        biu_awvalid = 1'b0;
        bvalid = 1'b1;
        repeat (4) step();
        bvalid = 1'b0;
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
